// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RV32 instruction front end.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [1:0]      INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small skid FIFO holding fetched {pc, instr} pairs between memory response and decode.
import riscv_pkg::*;

module fetch_skid_fifo #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, tracks the one outstanding memory read and feeds decode.
//   state | meaning
//   WAIT  | first cycle after reset release, memory still waking up, no issue
//   RUN   | issuing sequentially, honouring redirects and backpressure
//   HALT  | misaligned redirect seen, fetch stopped until reset
import riscv_pkg::*;

module instr_fetch_unit #(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Instruction_Code,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            fault_q, fault_d;

    logic             flush;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    logic             room;

    assign pop       = if_valid && if_ready;
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign room      = occupancy < OCC_W'(FIFO_DEPTH);
    // A response that lands in a redirect cycle belongs to the old stream.
    assign push      = inflight_q && !flush;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fault_d       = 1'b0;
        flush         = 1'b0;
        case (state_q)
            WAIT: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (is_misaligned(redirect_target[1:0])) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (room) begin
                    inflight_d    = 1'b1;
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
        end
    end

    fetch_skid_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .WIDTH     (2 * XLEN),
        .RESET_VAL ({RESET_PC, NOP_INSTR}),
        .CNT_W     (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .push_i  (push),
        .wdata_i ({inflight_pc_q, Instruction_Code}),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o ({if_pc, if_instr}),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign PC          = pc_q;
    assign if_valid    = !fifo_empty;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit with a registered-read instruction memory and a stream-order model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC               (PC),
        .Instruction_Code (Instruction_Code),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .fetch_fault      (fetch_fault)
    );

    // Program image; anything at or beyond 0x3C reads back as NOP.
    function automatic logic [31:0] image(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h0094_0333;
            32'h04:  return 32'h4139_03b3;
            32'h08:  return 32'h035a_02b3;
            32'h0C:  return 32'h017b_4e33;
            32'h10:  return 32'h0010_0093;
            32'h14:  return 32'h0020_0113;
            32'h18:  return 32'h0030_0193;
            32'h1C:  return 32'h0040_0213;
            32'h20:  return 32'h1234_5037;
            32'h24:  return 32'h0100_00EF;
            32'h28:  return 32'h0050_0293;
            32'h2C:  return 32'h0060_0313;
            32'h30:  return 32'h0070_0393;
            32'h34:  return 32'h0080_0413;
            32'h38:  return 32'h0090_0493;
            default: return NOP;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Instruction_Code <= NOP;
        else        Instruction_Code <= image(PC);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decode must see consecutive PCs from the last restart point, each paired with
    // its image word; a stalled head is frozen; a misaligned redirect gives one fault pulse
    // and silences fetch with PC frozen.
    logic [31:0] m_next_pc = 32'd0;
    logic        m_halted = 1'b0;
    logic        m_fault_due = 1'b0;
    logic        m_prev_stall = 1'b0;
    logic        m_prev_redir = 1'b0;
    logic [31:0] m_prev_pc = 32'd0;
    logic [31:0] m_prev_instr = 32'd0;
    logic [31:0] m_prev_PC = 32'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst if_valid", 32'(if_valid), 32'd0);
            chk("rst if_instr", if_instr, NOP);
            chk("rst if_pc", if_pc, 32'd0);
            chk("rst PC", PC, 32'd0);
            chk("rst fetch_fault", 32'(fetch_fault), 32'd0);
            m_next_pc    = 32'd0;
            m_halted     = 1'b0;
            m_fault_due  = 1'b0;
            m_prev_stall = 1'b0;
            m_prev_redir = 1'b0;
        end else begin
            chk("model fetch_fault", 32'(fetch_fault), 32'(m_fault_due));
            m_fault_due = 1'b0;
            if (m_halted) begin
                chk("model halt if_valid", 32'(if_valid), 32'd0);
                chk("model halt PC", PC, m_prev_PC);
            end
            if (m_prev_stall && !m_prev_redir) begin
                chk("model stall if_valid", 32'(if_valid), 32'd1);
                chk("model stall if_pc", if_pc, m_prev_pc);
                chk("model stall if_instr", if_instr, m_prev_instr);
            end
            if (if_valid && if_ready) begin
                chk("model pop pc", if_pc, m_next_pc);
                chk("model pop instr", if_instr, image(m_next_pc));
                m_next_pc = m_next_pc + 32'd4;
            end
            m_prev_redir = redirect_valid && !m_halted;
            if (redirect_valid && !m_halted) begin
                if (redirect_target[1:0] == 2'b00) begin
                    m_next_pc = redirect_target;
                end else begin
                    m_halted    = 1'b1;
                    m_fault_due = 1'b1;
                end
            end
            m_prev_stall = if_valid && !if_ready;
            m_prev_pc    = if_pc;
            m_prev_instr = if_instr;
        end
        m_prev_PC = PC;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc, input logic [31:0] instr);
        chk({name, " valid"}, 32'(if_valid), 32'd1);
        chk({name, " pc"}, if_pc, pc);
        chk({name, " instr"}, if_instr, instr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_pc [4];
        logic [31:0] t1_in [4];
        int          n;
        t1_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        t1_in = '{32'h0094_0333, 32'h4139_03b3, 32'h035a_02b3, 32'h017b_4e33};

        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        rst_n           = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset release: WAIT, then issue from 0, first word visible two cycles after issue.
        step();
        chk("t1 PC c1", PC, 32'h0);
        chk("t1 valid c1", 32'(if_valid), 32'd0);
        step();
        chk("t1 PC c2", PC, 32'h4);
        chk("t1 valid c2", 32'(if_valid), 32'd0);
        step();
        chk("t1 PC c3", PC, 32'h8);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk_head("t1 stream", t1_pc[i], t1_in[i]);
        end

        // Backpressure for five cycles with 0xC at the head.
        if_ready = 1'b0;
        repeat (5) step();
        chk("t2 PC frozen", PC, 32'h14);
        chk("t2 fifo count", 32'(dut.u_fifo.count_q), 32'd2);
        chk_head("t2 held head", 32'hC, 32'h017b_4e33);
        if_ready = 1'b1;
        step();
        chk_head("t2 resume 1", 32'h10, 32'h0010_0093);
        step();
        chk_head("t2 resume 2", 32'h14, 32'h0020_0113);
        step();
        chk_head("t2 resume 3", 32'h18, 32'h0030_0193);

        // Fill the FIFO, then reset asynchronously between edges.
        if_ready = 1'b0;
        repeat (3) step();
        chk("t5 fifo full", 32'(dut.u_fifo.count_q), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async if_valid", 32'(if_valid), 32'd0);
        chk("t5 async if_instr", if_instr, NOP);
        chk("t5 async if_pc", if_pc, 32'd0);
        chk("t5 async PC", PC, 32'd0);
        chk("t5 async fault", 32'(fetch_fault), 32'd0);
        step();
        step();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        repeat (3) step();
        chk_head("t5 restart", 32'h0, 32'h0094_0333);

        // Redirect to 0x20 in the cycle 0x8 is popped.
        n = 0;
        while (!(if_valid && if_pc == 32'h8) && n < 20) begin
            step();
            n++;
        end
        chk("t3 reached pc 8", 32'(if_valid && if_pc == 32'h8), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk("t3 PC target", PC, 32'h20);
        chk("t3 gap 1", 32'(if_valid), 32'd0);
        step();
        chk("t3 gap 2", 32'(if_valid), 32'd0);
        step();
        chk_head("t3 first", 32'h20, 32'h1234_5037);
        step();
        chk_head("t3 second", 32'h24, 32'h0100_00EF);

        // Redirect past the end of the image: NOPs delivered with their own PCs.
        redirect_valid  = 1'b1;
        redirect_target = 32'h3C;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk_head("t6 0x3C", 32'h3C, NOP);
        step();
        chk_head("t6 0x40", 32'h40, NOP);
        step();
        chk_head("t6 0x44", 32'h44, NOP);
        chk("t6 PC", PC, 32'h4C);

        // Misaligned redirect: one-cycle fault, fetch stops for good.
        redirect_valid  = 1'b1;
        redirect_target = 32'h22;
        step();
        redirect_valid = 1'b0;
        chk("t4 fault high", 32'(fetch_fault), 32'd1);
        chk("t4 valid low", 32'(if_valid), 32'd0);
        chk("t4 PC hold", PC, 32'h4C);
        step();
        chk("t4 fault pulse ends", 32'(fetch_fault), 32'd0);
        chk("t4 valid still low", 32'(if_valid), 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        chk("t4 halt ignores redirect PC", PC, 32'h4C);
        chk("t4 halt valid", 32'(if_valid), 32'd0);
        chk("t4 halt fault", 32'(fetch_fault), 32'd0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
